retire_trace_buf: RTL

Retirement trace capture for the uRISC pipeline. It sits directly downstream of the core top and samples the per-cycle retire signals: PC, register write, memory access and halt. Each retired instruction becomes a numbered trace record in a FIFO that a simulation or debug consumer drains through a valid/ready port. It also keeps cycle and instruction counters, flags halt, overflow and lost-progress conditions, and holds the halt record until every earlier record has drained.

---
 rtl/urisc_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/retire_trace_buf.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/urisc_pkg.sv
// Shared types for the uRISC retirement trace path.
// Holds the trace record layout, the capture FSM states and the counter width.
// No logic lives here; everything is combinationally free.
package urisc_pkg;

  localparam int TRACE_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    DONE       = 2'd2,
    ERR        = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_CNT_W-1:0] inum;
    logic [15:0]            pc;
    logic                   reg_write;
    logic [2:0]             dest_reg;
    logic [15:0]            dest_value;
    logic                   mem_read;
    logic                   mem_write;
    logic [15:0]            mem_addr;
    logic [15:0]            mem_data;
    logic                   halt;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DEPTH entries of WIDTH bits, head visible combinationally.
// Latency: a push at edge N is readable after edge N when the FIFO was empty.
// Backpressure: when full, a push is taken only if a pop happens in the same cycle.
// Ports: clk_i/rst_i (sync, active high); push_i/push_dat_i write side;
//        pop_i/pop_dat_o read side; full_o, empty_o, count_o status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign count_o   = cnt_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // The pop frees its slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/retire_trace_buf.sv
// Retirement trace capture: numbers each retired instruction and queues it for a consumer.
// Latency: a record captured at edge N is on trace_rec after edge N when the queue was empty.
// Backpressure: trace_ready low holds the head; a full queue with no pop drops the record (overflow).
// Ports: clk/rst (sync, active high); *_p1 retire inputs from the core;
//        trace_valid/trace_ready/trace_rec consumer port; inst_count, cycle_count,
//        halted, overflow, wdog_err status.
module retire_trace_buf
  import urisc_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   retire_valid_p1,
  input  logic [15:0]            pc_p1,
  input  logic                   reg_write_p1,
  input  logic [2:0]             dest_reg_p1,
  input  logic [15:0]            dest_value_p1,
  input  logic                   mem_read_p1,
  input  logic                   mem_write_p1,
  input  logic [15:0]            mem_addr_p1,
  input  logic [15:0]            mem_data_p1,
  input  logic                   halt_p1,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output trace_rec_t             trace_rec,
  output logic [TRACE_CNT_W-1:0] inst_count,
  output logic [TRACE_CNT_W-1:0] cycle_count,
  output logic                   halted,
  output logic                   overflow,
  output logic                   wdog_err
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  trace_state_e           state_q, state_d;
  logic [TRACE_CNT_W-1:0] inst_q, inst_d;
  logic [TRACE_CNT_W-1:0] cyc_q, cyc_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic [WDOG_W-1:0]      wdog_inc;
  trace_rec_t             halt_rec_q, halt_rec_d;
  logic                   halted_q, halted_d;
  logic                   ovf_q, ovf_d;
  logic                   wdog_err_q, wdog_err_d;

  trace_rec_t             cap_rec;
  trace_rec_t             fifo_dat;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    cap_rec            = '0;
    cap_rec.inum       = inst_q;
    cap_rec.pc         = pc_p1;
    cap_rec.reg_write  = reg_write_p1;
    cap_rec.dest_reg   = dest_reg_p1;
    cap_rec.dest_value = dest_value_p1;
    cap_rec.mem_read   = mem_read_p1;
    cap_rec.mem_write  = mem_write_p1;
    cap_rec.mem_addr   = mem_addr_p1;
    cap_rec.mem_data   = mem_data_p1;
    cap_rec.halt       = halt_p1;
  end

  // Halt records never enter the queue; they wait in halt_rec_q.
  assign fifo_push = (state_q == RUN) && retire_valid_p1 && !halt_p1;
  assign fifo_pop  = trace_ready && !fifo_empty && (state_q != DONE);
  assign wdog_inc  = wdog_q + 1'b1;

  sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifo_push),
    .push_dat_i (cap_rec),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    cyc_d       = cyc_q;
    wdog_d      = wdog_q;
    halt_rec_d  = halt_rec_q;
    halted_d    = halted_q;
    ovf_d       = ovf_q;
    wdog_err_d  = wdog_err_q;
    trace_valid = 1'b0;
    trace_rec   = '0;

    case (state_q)
      RUN: begin
        cyc_d       = cyc_q + 1'b1;
        trace_valid = !fifo_empty;
        if (!fifo_empty) trace_rec = fifo_dat;
        if (retire_valid_p1) begin
          wdog_d = '0;
          inst_d = inst_q + 1'b1;
          if (halt_p1) begin
            halt_rec_d = cap_rec;
            state_d    = HALT_DRAIN;
          end else if (fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
          end
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc >= WDOG_LIMIT) begin
            wdog_err_d = 1'b1;
            state_d    = ERR;
          end
        end
      end

      HALT_DRAIN: begin
        cyc_d       = cyc_q + 1'b1;
        trace_valid = 1'b1;
        // Earlier records go first; the halt record shows only once the queue is dry.
        if (fifo_count == '0) begin
          trace_rec = halt_rec_q;
          if (trace_ready) begin
            halted_d = 1'b1;
            state_d  = DONE;
          end
        end else begin
          trace_rec = fifo_dat;
        end
      end

      ERR: begin
        trace_valid = !fifo_empty;
        if (!fifo_empty) trace_rec = fifo_dat;
      end

      default: begin
        trace_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      inst_q     <= '0;
      cyc_q      <= '0;
      wdog_q     <= '0;
      halt_rec_q <= '0;
      halted_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      cyc_q      <= cyc_d;
      wdog_q     <= wdog_d;
      halt_rec_q <= halt_rec_d;
      halted_q   <= halted_d;
      ovf_q      <= ovf_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  assign halted      = halted_q;
  assign overflow    = ovf_q;
  assign wdog_err    = wdog_err_q;

endmodule
